// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the core and the RV32M mul/div unit
// The core drives the request side; the unit returns status and the write-back port.
interface muldiv_unit_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] busa;
   logic [XLEN-1:0] busb;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            regwr;

   modport master (
      output start, funct3, busa, busb, rd_in, flush,
      input  busy, done, result, rd_out, regwr
   );

   modport slave (
      input  start, funct3, busa, busb, rd_in, flush,
      output busy, done, result, rd_out, regwr
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
// Sign handling is done on magnitudes: operands are made positive at accept and fixed up at the end.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   muldiv_unit_if.slave       bus
);
   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_FIXUP = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              sign_q;
   logic              sign_r;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   rem;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;

   logic              a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   always_comb begin
      a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);
      sa       = a_signed & bus.busa[XLEN-1];
      sb       = b_signed & bus.busb[XLEN-1];
      mag_a    = sa ? ({XLEN{1'b0}} - bus.busa) : bus.busa;
      mag_b    = sb ? ({XLEN{1'b0}} - bus.busb) : bus.busb;
      div_zero = bus.funct3[2] && (bus.busb == {XLEN{1'b0}});
      div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                 (bus.busa == MIN_INT) && (bus.busb == {XLEN{1'b1}});
      special  = div_zero || div_ovf;
      if (div_zero)
         special_res = bus.funct3[1] ? bus.busa : {XLEN{1'b1}};
      else
         special_res = bus.funct3[1] ? {XLEN{1'b0}} : MIN_INT;
   end

   // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
   // Divide: acc[XLEN-1:0] shifts the dividend out on the left while quotient bits enter on the right.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift, div_trial;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      mul_next  = {mul_sum, acc[XLEN-1:1]};
      div_shift = {rem, acc[XLEN-1]};
      div_trial = div_shift - {1'b0, opnd};
      prod_fix  = sign_q ? ({(2*XLEN){1'b0}} - acc) : acc;
      quo_fix   = sign_q ? ({XLEN{1'b0}} - acc[XLEN-1:0]) : acc[XLEN-1:0];
      rem_fix   = sign_r ? ({XLEN{1'b0}} - rem) : rem;
      if (op[2])
         fix_res = op[1] ? rem_fix : quo_fix;
      else
         fix_res = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op       <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         rem      <= '0;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op   <= bus.funct3;
                  rd_q <= bus.rd_in;
                  cnt  <= '0;
                  if (special) begin
                     result_q <= special_res;
                     rd_out_q <= bus.rd_in;
                     state    <= S_DONE;
                  end else begin
                     sign_q <= sa ^ sb;
                     sign_r <= sa;
                     opnd   <= bus.funct3[2] ? mag_b : mag_a;
                     acc    <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
                     rem    <= '0;
                     state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (bus.flush) begin
                  state <= S_IDLE;
               end else begin
                  if (op[2]) begin
                     if (div_trial[XLEN]) begin
                        rem <= div_shift[XLEN-1:0];
                        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
                     end else begin
                        rem <= div_trial[XLEN-1:0];
                        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
                     end
                  end else begin
                     acc <= mul_next;
                  end
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(XLEN-1))
                     state <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               if (bus.flush) begin
                  state <= S_IDLE;
               end else begin
                  result_q <= fix_res;
                  rd_out_q <= rd_q;
                  state    <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = (state != S_IDLE);
   assign bus.done   = (state == S_DONE);
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;
   assign bus.regwr  = (state == S_DONE) && (rd_out_q != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Results are predicted with plain 64-bit integer arithmetic on the RV32M rules.
module tb_muldiv_unit;
   localparam int XLEN = 32;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();
   muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa64, sb64, ub64;
      logic [63:0]        p;
      int                 si, sj;
      sa64 = signed'({{32{a[31]}}, a});
      sb64 = signed'({{32{b[31]}}, b});
      ub64 = signed'({32'h0, b});
      si = int'(a);
      sj = int'(b);
      case (f)
         3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
         3'd1: begin p = sa64 * sb64; return p[63:32]; end
         3'd2: begin p = sa64 * ub64; return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
            return 32'(si / sj);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(si % sj);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF)))
         return 1;
      return XLEN + 2;
   endfunction

   // Issues one request and returns the cycle (counted from the accepting edge) in which done was seen.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.busa   = a;
      bus.busb   = b;
      bus.rd_in  = rd;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.funct3 = 3'($urandom);
      bus.busa   = $urandom;
      bus.busb   = $urandom;
      bus.rd_in  = 5'($urandom);
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.done) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.regwr} !== 3'b000 || bus.result !== 32'h0 || bus.rd_out !== 5'h0) begin
         errors++;
         $display("FAIL reset: busy/done/regwr=%b result=%h rd_out=%0d, required 000/0/0",
                  {bus.busy, bus.done, bus.regwr}, bus.result, bus.rd_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      vec_t v[11];
      int   lat;
      v[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      v[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
      v[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      v[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      v[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
      v[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
      v[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        34};
      v[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         34};
      v[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      v[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
      v[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      for (int i = 0; i < 11; i++) begin
         run_op(v[i].f, v[i].a, v[i].b, 5'd5, lat);
         checks++;
         if (bus.result !== v[i].exp || lat != v[i].lat) begin
            errors++;
            $display("FAIL directed[%0d]: result=%h cycle=%0d, required %h cycle %0d",
                     i, bus.result, lat, v[i].exp, v[i].lat);
         end
         checks++;
         if (bus.rd_out !== 5'd5 || bus.regwr !== 1'b1) begin
            errors++;
            $display("FAIL directed_wb[%0d]: rd_out=%0d regwr=%b, required 5 1", i, bus.rd_out, bus.regwr);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== v[i].exp) begin
            errors++;
            $display("FAIL pulse[%0d]: done=%b busy=%b result=%h, required 0 0 %h",
                     i, bus.done, bus.busy, bus.result, v[i].exp);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, e;
      logic [4:0]  rd;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         f  = 3'($urandom);
         a  = $urandom;
         b  = $urandom;
         rd = 5'($urandom_range(1, 31));
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         e = model(f, a, b);
         run_op(f, a, b, rd, lat);
         checks++;
         if (bus.result !== e || lat != model_lat(f, a, b) || bus.rd_out !== rd) begin
            errors++;
            $display("FAIL random[%0d] f=%0d a=%h b=%h: result=%h cycle=%0d rd=%0d, required %h cycle %0d rd %0d",
                     i, f, a, b, bus.result, lat, bus.rd_out, e, model_lat(f, a, b), rd);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] prev;
      int          lat;
      bit          seen;
      run_op(3'd3, 32'd1234, 32'd5678, 5'd7, lat);
      prev = model(3'd3, 32'd1234, 32'd5678);
      @(negedge clk);
      while (bus.busy) @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.busa = 32'd3; bus.busb = 32'd9; bus.rd_in = 5'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.result !== prev || bus.rd_out !== 5'd7) begin
         errors++;
         $display("FAIL flush: busy=%b result=%h rd_out=%0d, required 0 %h 7", bus.busy, bus.result, bus.rd_out, prev);
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush_quiet: activity=%b after flush, required 0", seen);
      end
      // flush together with start while idle must still accept the request
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd7; bus.busa = 32'd50; bus.busb = 32'd8; bus.rd_in = 5'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (bus.result !== 32'd2 || lat != 34) begin
         errors++;
         $display("FAIL flush_start_idle: result=%h cycle=%0d, required 00000002 cycle 34", bus.result, lat);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      @(negedge clk);
      while (bus.busy) @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.busa = 32'd11; bus.busb = 32'd13; bus.rd_in = 5'd4;
      @(posedge clk);
      #1;
      bus.funct3 = 3'd5; bus.busa = 32'd1; bus.busb = 32'd0; bus.rd_in = 5'd8;
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.result !== 32'd143 || lat != 34 || bus.rd_out !== 5'd4) begin
         errors++;
         $display("FAIL busy_ignore: result=%h cycle=%0d rd=%0d, required 0000008f cycle 34 rd 4",
                  bus.result, lat, bus.rd_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL not_queued: busy=%b done=%b, required 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_rd_zero();
      int lat;
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd0, lat);
      checks++;
      if (bus.done !== 1'b1 || bus.regwr !== 1'b0 || bus.result !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL rd_zero: done=%b regwr=%b result=%h, required 1 0 ffffffff", bus.done, bus.regwr, bus.result);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      while (bus.busy) @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd4; bus.busa = 32'd1000; bus.busb = 32'd3; bus.rd_in = 5'd12;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.regwr} !== 3'b000 || bus.result !== 32'h0 || bus.rd_out !== 5'h0) begin
         errors++;
         $display("FAIL reset_mid: busy/done/regwr=%b result=%h rd_out=%0d, required 000/0/0",
                  {bus.busy, bus.done, bus.regwr}, bus.result, bus.rd_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_nodone: done seen=%b, required 0", seen);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
      bus.busa = 32'h0; bus.busb = 32'h0; bus.rd_in = 5'd0;
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_busy_ignore();
      test_rd_zero();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
